// File: rtl/ss_score_display_if.sv
// rtl/ss_score_display_if.sv - Digit/segment bundle between the score counters, the display driver and the board pins
//
// Purpose: groups the score-side inputs and the pin-side outputs of
// ss_score_display so producers and the driver share one connection.
// Signals:
//   bcd_in     packed BCD digits, digit k in bits [4k+3:4k]
//   load       latch bcd_in into the driver's shadow register
//   lz_blank   enable leading-zero blanking
//   blink_en   enable whole-display blinking
//   seg        active-low segments {g,f,e,d,c,b,a}
//   an         active-low one-hot anode select
//   digit_idx  index of the digit currently on seg/an
// Modports: master drives the controls and observes the pins; slave is the driver.
interface ss_score_display_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    load;
  logic                    lz_blank;
  logic                    blink_en;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;

  modport master (
    output bcd_in, load, lz_blank, blink_en,
    input  seg, an, digit_idx
  );

  modport slave (
    input  bcd_in, load, lz_blank, blink_en,
    output seg, an, digit_idx
  );
endinterface

// File: rtl/ss_score_display.sv
// rtl/ss_score_display.sv - Multiplexed common-anode seven-segment driver for the BCD score chain
//
// Purpose: snapshots the BCD score on load, scans one digit per refresh slot,
// blanks leading zeros and optionally blinks the whole display.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   ss_score_display_if.slave: bcd_in/load/lz_blank/blink_en in,
//         registered seg/an/digit_idx out
module ss_score_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_SCANS = 64
) (
  input  logic             clk,
  input  logic             rst,
  ss_score_display_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int RND_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(BLINK_SCANS - 1);

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } phase_t;

  logic [4*NUM_DIGITS-1:0] shadow, shadow_next;
  logic [PRE_W-1:0]        presc, presc_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic [RND_W-1:0]        rnd, rnd_next;
  phase_t                  phase, phase_next;

  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [3:0]              cur_digit;
  logic [3:0]              scan_digit;
  logic                    upper_zero;
  logic                    blank;
  logic                    dark;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F; // non-BCD code: dash (segment g only)
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow        <= '0;
      presc         <= '0;
      idx           <= '0;
      rnd           <= '0;
      phase         <= PHASE_ON;
      bus.seg       <= 7'h7F;
      bus.an        <= '1;
      bus.digit_idx <= '0;
    end else begin
      shadow        <= shadow_next;
      presc         <= presc_next;
      idx           <= idx_next;
      rnd           <= rnd_next;
      phase         <= phase_next;
      bus.seg       <= seg_next;
      bus.an        <= an_next;
      bus.digit_idx <= idx;
    end
  end

  // Scan timing: prescaler -> digit index -> scan rounds -> blink phase.
  always_comb begin
    shadow_next = shadow;
    presc_next  = presc + 1'b1;
    idx_next    = idx;
    rnd_next    = rnd;
    phase_next  = phase;

    if (bus.load) begin
      shadow_next = bus.bcd_in;
    end

    if (presc == PRE_LAST) begin
      presc_next = '0;
      if (idx == IDX_LAST) begin
        idx_next = '0;
        if (rnd == RND_LAST) begin
          rnd_next   = '0;
          phase_next = (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
        end else begin
          rnd_next = rnd + 1'b1;
        end
      end else begin
        idx_next = idx + 1'b1;
      end
    end
  end

  // Output stage works from the shadow register only. Walking from the most
  // significant digit down keeps a running "everything above is zero" flag,
  // which is exactly the leading-zero condition for the selected digit.
  always_comb begin
    upper_zero = 1'b1;
    cur_digit  = '0;
    scan_digit = '0;
    blank      = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      scan_digit = shadow[4*k +: 4];
      upper_zero = upper_zero && (scan_digit == 4'd0);
      if (idx == IDX_W'(k)) begin
        cur_digit = scan_digit;
        blank     = bus.lz_blank && (k != 0) && upper_zero;
      end
    end

    dark     = bus.blink_en && (phase == PHASE_OFF);
    an_next  = '1;
    seg_next = 7'h7F;
    if (!dark) begin
      an_next[idx] = 1'b0;
      seg_next     = blank ? 7'h7F : decode(cur_digit);
    end
  end

endmodule
